// File: rtl/instruction_fetch_pkg.sv
// ----------------------------------------------------------------------------
// FetchPackage
// Shared types and constants for the instruction-fetch stage.
//   FetchEntry      : {pc, instr} record held in the output FIFO.
//   INSTR_BYTES     : PC increment per fetched instruction.
//   PC_READ_LATENCY : cycles from pcAddress to pcDataOutput on the Memory PC
//                     port; sets the depth of the in-flight tracking pipe.
// ----------------------------------------------------------------------------
package FetchPackage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } FetchEntry;

    localparam int unsigned INSTR_BYTES     = 4;
    localparam int unsigned PC_READ_LATENCY = 2;

    // Instructions are word aligned; low address bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_if
// Bundles the fetch stage's Memory PC-port signals and its decode-side
// valid/ready output.
//   master : fetch stage view (drives pcAddress and out_*).
//   slave  : environment view (Memory, control and decode).
// ----------------------------------------------------------------------------
interface instruction_fetch_if;

    logic [31:0] pcAddress;
    logic [31:0] pcDataOutput;
    logic        fetch_enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;

    modport master (
        output pcAddress,
        input  pcDataOutput,
        input  fetch_enable,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instruction
    );

    modport slave (
        input  pcAddress,
        output pcDataOutput,
        output fetch_enable,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instruction
    );

endinterface

// File: rtl/instruction_fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of FetchEntry records between the memory capture point and
// decode.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write push_data_i at the tail
//   push_data_i   : entry to write
//   pop_i         : drop the head entry (ignored when empty)
//   flush_i       : empty the FIFO; overrides push and pop
//   full_o        : DEPTH entries held
//   empty_o       : no entries held
//   count_o       : number of entries held, 0..DEPTH
//   head_o        : oldest entry (undefined when empty)
// DEPTH must be a power of two so pointers wrap naturally.
// ----------------------------------------------------------------------------
module fetch_fifo
    import FetchPackage::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  FetchEntry       push_data_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o,
    output FetchEntry       head_o
);

    FetchEntry       mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !flush_i;
        do_pop   = pop_i && !empty_o && !flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: empty_o gates every read of it.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage in front of the Memory PC port. Owns the PC, tracks reads in
// flight through a PC_READ_LATENCY-deep valid pipe, buffers returned words in
// a FIFO and presents {pc, instruction} to decode over valid/ready.
//   clk            : clock, rising edge
//   rst            : asynchronous active-low reset
//   bus.pcAddress  : current fetch address (= pc_q)
//   bus.pcDataOutput : memory word, valid PC_READ_LATENCY cycles after address
//   bus.fetch_enable : 1 = issue new fetches, 0 = hold the PC
//   bus.redirect_valid / redirect_pc : taken branch/jump, flushes in-flight
//   bus.out_valid / out_ready / out_pc / out_instruction : decode handshake
// ----------------------------------------------------------------------------
module instruction_fetch
    import FetchPackage::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                 clk,
    input logic                 rst,
    instruction_fetch_if.master bus
);

    localparam int unsigned CntW      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LastStage = PC_READ_LATENCY - 1;

    logic [31:0]                pc_q, pc_d;
    // Stage 0 is s1 (address just issued), LastStage is s2 (data on the bus).
    logic [PC_READ_LATENCY-1:0] stage_valid_q, stage_valid_d;
    logic [31:0]                stage_pc_q [PC_READ_LATENCY];
    logic [31:0]                stage_pc_d [PC_READ_LATENCY];

    logic            issue;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_flush;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_count;
    FetchEntry       push_entry;
    FetchEntry       head_entry;
    int unsigned     credits_used;

    always_comb begin
        // Every read in flight has a reserved FIFO slot, so a capture can
        // never find the FIFO full. A pop this cycle frees its slot next cycle.
        credits_used = 32'(fifo_count);
        for (int i = 0; i < PC_READ_LATENCY; i++) begin
            credits_used += 32'(stage_valid_q[i]);
        end
        issue = bus.fetch_enable && !bus.redirect_valid && (credits_used < FIFO_DEPTH);

        pc_d = pc_q;
        if (bus.redirect_valid) begin
            pc_d = align_pc(bus.redirect_pc);
        end else if (issue) begin
            pc_d = pc_q + INSTR_BYTES;
        end

        stage_valid_d[0] = issue;
        stage_pc_d[0]    = pc_q;
        for (int i = 1; i < PC_READ_LATENCY; i++) begin
            stage_valid_d[i] = stage_valid_q[i-1] && !bus.redirect_valid;
            stage_pc_d[i]    = stage_pc_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            stage_valid_q <= '0;
            for (int i = 0; i < PC_READ_LATENCY; i++) stage_pc_q[i] <= '0;
        end else begin
            pc_q          <= pc_d;
            stage_valid_q <= stage_valid_d;
            for (int i = 0; i < PC_READ_LATENCY; i++) stage_pc_q[i] <= stage_pc_d[i];
        end
    end

    // A redirect discards the word landing this edge along with the FIFO.
    assign fifo_flush = bus.redirect_valid;
    assign fifo_push  = stage_valid_q[LastStage] && !bus.redirect_valid;
    assign fifo_pop   = !fifo_empty && bus.out_ready;
    assign push_entry = '{pc: stage_pc_q[LastStage], instr: bus.pcDataOutput};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (rst),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .flush_i     (fifo_flush),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .head_o      (head_entry)
    );

    assign bus.pcAddress       = pc_q;
    assign bus.out_valid       = !fifo_empty;
    assign bus.out_pc          = fifo_empty ? 32'h0 : head_entry.pc;
    assign bus.out_instruction = fifo_empty ? 32'h0 : head_entry.instr;

`ifndef SYNTHESIS
    // The credit scheme must make a push into a full FIFO impossible.
    always @(posedge clk) begin
        if (rst && fifo_push) assert (!fifo_full);
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    instruction_fetch_if bus ();

    instruction_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word[i] = 0x1000_0000 + i, two-cycle read latency.
    function automatic logic [31:0] word(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    logic [31:0] mem_a1;
    always @(posedge clk) begin
        mem_a1           <= bus.pcAddress;
        bus.pcDataOutput <= word(mem_a1);
    end

    typedef struct {
        logic        rst_n;
        logic        fe;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        exp_v;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic fe, input logic rdy, input logic rv,
                       input logic [31:0] rpc, input logic ev, input logic [31:0] epc,
                       input logic [31:0] eaddr);
        vec_t v;
        v = '{r, fe, rdy, rv, rpc, ev, epc, eaddr};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    logic [31:0] exp_next;
    int          handshakes;
    int          wait_cycles;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b0;
        bus.fetch_enable   = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b0;

        //  rst fe rdy rv rpc            ev pc             addr
        // Reset release, streaming with out_ready=1.
        add(0, 1, 1, 0, 32'h0,          0, 32'h0,          32'h0);
        add(1, 1, 1, 0, 32'h0,          0, 32'h0,          32'h0);
        add(1, 1, 1, 0, 32'h0,          0, 32'h0,          32'h4);
        add(1, 1, 1, 0, 32'h0,          0, 32'h0,          32'h8);
        add(1, 1, 1, 0, 32'h0,          1, 32'h0,          32'hC);
        add(1, 1, 1, 0, 32'h0,          1, 32'h4,          32'h10);
        add(1, 1, 1, 0, 32'h0,          1, 32'h8,          32'h14);
        // Async reset mid-stream, then 10 cycles of backpressure.
        add(0, 1, 1, 0, 32'h0,          0, 32'h0,          32'h0);
        add(1, 1, 0, 0, 32'h0,          0, 32'h0,          32'h0);
        add(1, 1, 0, 0, 32'h0,          0, 32'h0,          32'h4);
        add(1, 1, 0, 0, 32'h0,          0, 32'h0,          32'h8);
        add(1, 1, 0, 0, 32'h0,          1, 32'h0,          32'hC);
        for (int i = 0; i < 6; i++) add(1, 1, 0, 0, 32'h0, 1, 32'h0, 32'h10);
        add(1, 1, 1, 0, 32'h0,          1, 32'h0,          32'h10);
        add(1, 1, 1, 0, 32'h0,          1, 32'h4,          32'h10);
        add(1, 1, 1, 0, 32'h0,          1, 32'h8,          32'h14);
        add(1, 1, 1, 0, 32'h0,          1, 32'hC,          32'h18);
        add(1, 1, 1, 0, 32'h0,          1, 32'h10,         32'h1C);
        // Build 3 buffered entries, then redirect to 0x102.
        add(1, 1, 0, 0, 32'h0,          1, 32'h14,         32'h20);
        add(1, 1, 0, 0, 32'h0,          1, 32'h14,         32'h24);
        add(1, 1, 1, 1, 32'h0000_0102,  1, 32'h14,         32'h24);
        add(1, 1, 1, 0, 32'h0,          0, 32'h0,          32'h100);
        add(1, 1, 1, 0, 32'h0,          0, 32'h0,          32'h104);
        add(1, 1, 1, 0, 32'h0,          0, 32'h0,          32'h108);
        add(1, 1, 1, 0, 32'h0,          1, 32'h100,        32'h10C);
        add(1, 1, 1, 0, 32'h0,          1, 32'h104,        32'h110);
        // fetch_enable low for 5 cycles.
        add(1, 0, 1, 0, 32'h0,          1, 32'h108,        32'h114);
        add(1, 0, 1, 0, 32'h0,          1, 32'h10C,        32'h114);
        add(1, 0, 1, 0, 32'h0,          1, 32'h110,        32'h114);
        add(1, 0, 1, 0, 32'h0,          0, 32'h0,          32'h114);
        add(1, 0, 1, 0, 32'h0,          0, 32'h0,          32'h114);
        add(1, 1, 1, 0, 32'h0,          0, 32'h0,          32'h114);
        add(1, 1, 1, 0, 32'h0,          0, 32'h0,          32'h118);
        add(1, 1, 1, 0, 32'h0,          0, 32'h0,          32'h11C);
        add(1, 1, 1, 0, 32'h0,          1, 32'h114,        32'h120);
        add(1, 1, 1, 0, 32'h0,          1, 32'h118,        32'h124);
        // PC wrap through 2^32.
        add(1, 1, 1, 1, 32'hFFFF_FFF8,  1, 32'h11C,        32'h128);
        add(1, 1, 1, 0, 32'h0,          0, 32'h0,          32'hFFFF_FFF8);
        add(1, 1, 1, 0, 32'h0,          0, 32'h0,          32'hFFFF_FFFC);
        add(1, 1, 1, 0, 32'h0,          0, 32'h0,          32'h0);
        add(1, 1, 1, 0, 32'h0,          1, 32'hFFFF_FFF8,  32'h4);
        add(1, 1, 1, 0, 32'h0,          1, 32'hFFFF_FFFC,  32'h8);
        add(1, 1, 1, 0, 32'h0,          1, 32'h0,          32'hC);
        add(1, 1, 1, 0, 32'h0,          1, 32'h4,          32'h10);
        // Back-to-back redirects: the second wins.
        add(1, 1, 1, 1, 32'h0000_0200,  1, 32'h8,          32'h14);
        add(1, 1, 1, 1, 32'h0000_0303,  0, 32'h0,          32'h200);
        add(1, 1, 1, 0, 32'h0,          0, 32'h0,          32'h300);
        add(1, 1, 1, 0, 32'h0,          0, 32'h0,          32'h304);
        add(1, 1, 1, 0, 32'h0,          0, 32'h0,          32'h308);
        add(1, 1, 1, 0, 32'h0,          1, 32'h300,        32'h30C);

        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[k]) begin
            rst                = vecs[k].rst_n;
            bus.fetch_enable   = vecs[k].fe;
            bus.out_ready      = vecs[k].rdy;
            bus.redirect_valid = vecs[k].rv;
            bus.redirect_pc    = vecs[k].rpc;
            #1;
            check($sformatf("row%0d out_valid", k), 32'(bus.out_valid), 32'(vecs[k].exp_v));
            check($sformatf("row%0d out_pc", k), bus.out_pc, vecs[k].exp_pc);
            check($sformatf("row%0d out_instruction", k), bus.out_instruction,
                  vecs[k].exp_v ? word(vecs[k].exp_pc) : 32'h0);
            check($sformatf("row%0d pcAddress", k), bus.pcAddress, vecs[k].exp_addr);
            @(posedge clk);
            #1;
        end

        // Random out_ready: the stream must stay in order with a stable head.
        bus.fetch_enable   = 1'b1;
        bus.redirect_valid = 1'b0;
        exp_next   = 32'h304;
        handshakes = 0;
        for (int i = 0; i < 80; i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus.out_valid) begin
                check($sformatf("rand%0d out_pc", i), bus.out_pc, exp_next);
                check($sformatf("rand%0d out_instruction", i), bus.out_instruction,
                      word(exp_next));
                if (bus.out_ready) begin
                    exp_next = exp_next + 32'h4;
                    handshakes++;
                end
            end
            @(posedge clk);
            #1;
        end
        check("rand handshakes>10", 32'(handshakes > 10), 32'h1);

        // Async reset asserted between edges takes effect immediately.
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("async rst out_valid", 32'(bus.out_valid), 32'h0);
        check("async rst pcAddress", bus.pcAddress, 32'h0);
        check("async rst out_pc", bus.out_pc, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_cycles = 0;
        while (!bus.out_valid && wait_cycles < 10) begin
            @(posedge clk);
            #1;
            wait_cycles++;
        end
        check("restart latency", 32'(wait_cycles), 32'd3);
        check("restart out_pc", bus.out_pc, 32'h0);
        check("restart out_instruction", bus.out_instruction, 32'h1000_0000);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("restart seq%0d out_pc", i), bus.out_pc, 32'(i * 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Instruction-fetch stage directly upstream of the Memory block's PC port.
- Owns the program counter, drives Memory.pcAddress and consumes Memory.pcDataOutput, which arrives 2 cycles after the address is presented.
- Tracks in-flight reads, buffers returned words in a small FIFO and hands {pc, instruction} to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing everything in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
FIFO_DEPTH, 4, output buffer entries; power of two, >=4 for one fetch per cycle.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
pcAddress  output  32  byte address of the instruction being fetched, word aligned; to Memory.pcAddress.
pcDataOutput  input  32  instruction word from Memory, valid 2 cycles after the matching pcAddress.
fetch_enable  input  1  1 = issue new fetches; 0 = hold PC, in-flight reads still land.
redirect_valid  input  1  branch/jump taken this cycle.
redirect_pc  input  32  new fetch target; bits [1:0] forced to 0.
out_valid  output  1  FIFO head holds a valid instruction.
out_ready  input  1  decode accepts head this cycle.
out_pc  output  32  byte address of the head instruction.
out_instruction  output  32  head instruction word.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-low.
- Reset (rst=0, any time, including mid-operation):
  - pc_q=RESET_PC; in-flight valids s1=s2=0; FIFO empty.
  - out_valid=0, out_pc=0, out_instruction=0; pcAddress=RESET_PC.
  - All in-flight data is dropped.
- pcAddress = pc_q, combinationally.
- Issue condition for cycle t: issue = fetch_enable & !redirect_valid & (fifo_count + s1 + s2 < FIFO_DEPTH).
  - A same-cycle pop does not free a credit until the next cycle.
- On issue at the edge ending cycle t:
  - pc_q <= pc_q + 4, wrapping mod 2^32 (32'hFFFF_FFFC -> 0).
  - s1 <= 1 with s1_pc <= pc_q.
- Without issue: s1 <= 0 and pc_q holds. Memory keeps reading the held address; that data is ignored.
- In-flight pipe advances every edge: s2 <= s1, s2_pc <= s1_pc.
- Capture: when s2=1 in cycle t+2, pcDataOutput is the word for s2_pc; at that edge push {s2_pc, pcDataOutput} into the FIFO.
  - The credit rule guarantees the FIFO is never full on a push, so there is no overflow path.
  - Push into a full FIFO is an assertion failure.
- Latency: address presented in cycle t -> out_valid in cycle t+3.
- Throughput: 1 instruction/cycle with out_ready held at 1 and FIFO_DEPTH>=4.
- Output:
  - out_valid = !fifo_empty; out_pc/out_instruction = head entry, or 0 when empty.
  - Pop on out_valid & out_ready.
  - Head must stay stable while out_valid & !out_ready.
- FIFO:
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Redirect (redirect_valid=1 at an edge), highest priority after reset:
  - pc_q <= {redirect_pc[31:2], 2'b00}.
  - s1 <= 0, s2 <= 0, FIFO flushed to empty.
  - No issue that cycle; any capture that edge is discarded.
  - A pop handshaked in the same cycle counts as consumed by decode.
  - Next cycle: out_valid=0 and pcAddress = new target.
  - First post-redirect instruction: redirect in cycle r -> out_valid in cycle r+4.
- Back-to-back redirects: the last one wins; each flushes again.
- fetch_enable=0: s1/s2 drain into the FIFO normally; pc_q frozen. Re-enable resumes from pc_q with no duplicate or skipped PCs.

Decomposition:
- Package FetchPackage:
  - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} FetchEntry.
  - localparam INSTR_BYTES=4.
  - localparam PC_READ_LATENCY=2, the Memory PC-port latency; the s1/s2 depth derives from it.
- Sub-module fetch_fifo:
  - Synchronous FIFO of FetchEntry, parameter DEPTH.
  - Ports: push, pop, flush, full, empty, count, head.
  - Async active-low reset; flush takes priority over push/pop.

Test Plan:
- Reset release with RESET_PC=0, memory word[i]=32'h1000_0000+i, out_ready=1:
  - pcAddress 0,4,8,... one per cycle.
  - First out_valid 3 cycles after reset release, with out_pc=0, out_instruction=32'h1000_0000.
  - Then consecutive PCs every cycle.
- Backpressure, out_ready=0 for 10 cycles:
  - Exactly 4 entries buffered (pc 0..12); pcAddress frozen at 16.
  - No drops and head stable.
  - out_ready=1 then yields pc 0,4,8,12,16 in order.
- Redirect to 32'h0000_0102 while 3 instructions are buffered:
  - Next cycle out_valid=0 and pcAddress=32'h0000_0100.
  - First output pc=32'h100 three cycles later; none of the old PCs ever appear.
- fetch_enable=0 for 5 cycles mid-stream:
  - In-flight 2 words still delivered; PC sequence has no gaps or duplicates after re-enable.
- Wrap: redirect to 32'hFFFF_FFF8:
  - Outputs pc FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Async reset asserted mid-stream between clock edges:
  - out_valid=0 and pcAddress=RESET_PC immediately.
  - After release, the sequence restarts from RESET_PC.
